// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit bus: instruction/data memory handshakes, trap acknowledge, datapath strobes.
// Purely combinational signal bundle, no latency of its own.
// Memory waits are signalled by the ready inputs; the controller holds its strobes until ready.
interface mc_ctrl_fsm_if;
    // Instruction fields and handshakes into the controller
    logic [3:0] op;
    logic [3:0] func;
    logic       imem_ready;
    logic       dmem_ready;
    logic       trap_clr;

    // Datapath strobes out of the controller
    logic       IntMemRead;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCSrc;
    logic       FlagSel;
    logic       IRRead;
    logic       RegRead;
    logic       Muxgrp;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUSrc1;
    logic [1:0] ALUSrc2;
    logic [2:0] ALUop;

    // Status
    logic [4:0] state;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    // Controller side
    modport master (
        input  op, func, imem_ready, dmem_ready, trap_clr,
        output IntMemRead, IRWrite, PCWrite, PCWriteCond, PCSrc, FlagSel,
               IRRead, RegRead, Muxgrp, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUSrc1, ALUSrc2, ALUop, state, retire, trap, trap_cause
    );

    // Datapath / memory side
    modport slave (
        output op, func, imem_ready, dmem_ready, trap_clr,
        input  IntMemRead, IRWrite, PCWrite, PCWriteCond, PCSrc, FlagSel,
               IRRead, RegRead, Muxgrp, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUSrc1, ALUSrc2, ALUop, state, retire, trap, trap_cause
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: IF/ID/EX/MEM/WB sequencing with illegal-op and bus-timeout traps.
// ALU/branch/jump 3 cycles, store 4, load 5, plus one cycle per memory wait cycle.
// Stalls in IF/MEM states while the matching ready is low; bounded by TIMEOUT wait cycles.
module mc_ctrl_fsm #(
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT   = 15,
    parameter int TRAP_EN   = 1
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_fsm_if.master  bus
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX     = 5'd2,
        S_MEM_LD = 5'd3,
        S_MEM_ST = 5'd4,
        S_WB     = 5'd5,
        S_TRAP   = 5'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_REG = 3'd0,
        C_ALU_IMM = 3'd1,
        C_SHIFT   = 3'd2,
        C_BRANCH  = 3'd3,
        C_JUMP    = 3'd4,
        C_LOAD    = 3'd5,
        C_STORE   = 3'd6
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] aluop;
        logic       flag_sel;
    } cls_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_SRL  = 3'b011;
    localparam logic [2:0] ALU_SRA  = 3'b100;
    localparam logic [2:0] ALU_NAND = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Last wait-counter value before an access is declared dead
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    cls_t                 cls_q, cls_d;
    logic [1:0]           cause_q, cause_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;

    cls_t                 dec_cls;
    logic                 dec_legal;
    logic                 mem_wait;
    logic                 wait_expired;

    // Registered state: FSM, latched instruction class, wait counter, trap cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cls_q   <= '0;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // Opcode decode into class, ALU operation and branch flag select
    always_comb begin
        dec_legal        = 1'b1;
        dec_cls.kind     = C_ALU_REG;
        dec_cls.aluop    = ALU_ADD;
        dec_cls.flag_sel = 1'b0;
        case (bus.op)
            4'b1000: begin dec_cls.kind = C_ALU_REG; dec_cls.aluop = ALU_ADD;  end
            4'b1001,
            4'b1010: begin dec_cls.kind = C_ALU_IMM; dec_cls.aluop = ALU_ADD;  end
            4'b1100: begin dec_cls.kind = C_ALU_REG; dec_cls.aluop = ALU_SUB;  end
            4'b1101,
            4'b1110: begin dec_cls.kind = C_ALU_IMM; dec_cls.aluop = ALU_SUB;  end
            4'b1011: begin dec_cls.kind = C_ALU_REG; dec_cls.aluop = ALU_NAND; end
            4'b1111: begin dec_cls.kind = C_ALU_REG; dec_cls.aluop = ALU_OR;   end
            4'b0111: begin dec_cls.kind = C_ALU_IMM; dec_cls.aluop = ALU_NAND; end
            4'b0110: begin dec_cls.kind = C_ALU_IMM; dec_cls.aluop = ALU_OR;   end
            4'b0100: begin dec_cls.kind = C_BRANCH;  dec_cls.aluop = ALU_SUB;  end
            4'b0101: begin
                dec_cls.kind     = C_BRANCH;
                dec_cls.aluop    = ALU_SUB;
                dec_cls.flag_sel = 1'b1;
            end
            4'b0011: dec_cls.kind = C_JUMP;
            4'b0001: dec_cls.kind = C_LOAD;
            4'b0010: dec_cls.kind = C_STORE;
            4'b0000: begin
                // Shift group: the function field picks the shift, anything else is illegal
                dec_cls.kind = C_SHIFT;
                case (bus.func)
                    4'b0001: dec_cls.aluop = ALU_SLL;
                    4'b0010: dec_cls.aluop = ALU_SRL;
                    4'b0011: dec_cls.aluop = ALU_SRA;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Memory stall detection; ready in the last allowed cycle beats the timeout
    always_comb begin
        mem_wait = 1'b0;
        case (state_q)
            S_IF:     mem_wait = !bus.imem_ready;
            S_MEM_LD,
            S_MEM_ST: mem_wait = !bus.dmem_ready;
            default:  mem_wait = 1'b0;
        endcase
        wait_expired = mem_wait && (wait_q == WAIT_LAST);
    end

    // Next state, class/cause updates and every datapath strobe
    always_comb begin
        state_d         = state_q;
        cls_d           = cls_q;
        cause_d         = cause_q;

        bus.IntMemRead  = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.FlagSel     = 1'b0;
        bus.IRRead      = 1'b0;
        bus.RegRead     = 1'b0;
        bus.Muxgrp      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.ALUSrc1     = 2'b00;
        bus.ALUSrc2     = 2'b00;
        bus.ALUop       = ALU_ADD;
        bus.retire      = 1'b0;
        bus.trap        = 1'b0;

        case (state_q)
            S_IF: begin
                // PC + 1 computed while waiting for the instruction word
                bus.IntMemRead = 1'b1;
                bus.ALUSrc1    = 2'b00;
                bus.ALUSrc2    = 2'b01;
                bus.ALUop      = ALU_ADD;
                bus.PCWrite    = bus.imem_ready;
                bus.IRWrite    = bus.imem_ready;
                if (bus.imem_ready) begin
                    state_d = S_ID;
                end else if (wait_expired && (TRAP_EN != 0)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_ID: begin
                bus.IRRead  = 1'b1;
                bus.RegRead = 1'b1;
                bus.Muxgrp  = 1'b1;
                if (dec_legal) begin
                    state_d = S_EX;
                    cls_d   = dec_cls;
                end else if (TRAP_EN != 0) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_IF;
                end
            end
            S_EX: begin
                bus.ALUop = cls_q.aluop;
                state_d   = S_IF;
                case (cls_q.kind)
                    C_ALU_REG: begin
                        bus.ALUSrc1  = 2'b01;
                        bus.ALUSrc2  = 2'b00;
                        bus.MemtoReg = 1'b1;
                        bus.RegWrite = 1'b1;
                        bus.retire   = 1'b1;
                    end
                    C_ALU_IMM: begin
                        bus.ALUSrc1  = 2'b10;
                        bus.ALUSrc2  = 2'b10;
                        bus.MemtoReg = 1'b1;
                        bus.RegWrite = 1'b1;
                        bus.retire   = 1'b1;
                    end
                    C_SHIFT: begin
                        bus.ALUSrc1  = 2'b10;
                        bus.ALUSrc2  = 2'b00;
                        bus.MemtoReg = 1'b1;
                        bus.RegWrite = 1'b1;
                        bus.retire   = 1'b1;
                    end
                    C_BRANCH: begin
                        bus.PCSrc       = 1'b1;
                        bus.PCWriteCond = 1'b1;
                        bus.ALUSrc1     = 2'b01;
                        bus.ALUSrc2     = 2'b00;
                        bus.FlagSel     = cls_q.flag_sel;
                        bus.retire      = 1'b1;
                    end
                    C_JUMP: begin
                        bus.PCWrite = 1'b1;
                        bus.ALUSrc1 = 2'b00;
                        bus.ALUSrc2 = 2'b11;
                        bus.retire  = 1'b1;
                    end
                    C_LOAD: begin
                        bus.ALUSrc1 = 2'b01;
                        bus.ALUSrc2 = 2'b10;
                        state_d     = S_MEM_LD;
                    end
                    C_STORE: begin
                        bus.ALUSrc1 = 2'b01;
                        bus.ALUSrc2 = 2'b10;
                        state_d     = S_MEM_ST;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM_LD: begin
                bus.MemRead = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_expired && (TRAP_EN != 0)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_ST: begin
                bus.MemWrite = 1'b1;
                if (bus.dmem_ready) begin
                    bus.retire = 1'b1;
                    state_d    = S_IF;
                end else if (wait_expired && (TRAP_EN != 0)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                bus.MemtoReg = 1'b0;
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
                state_d      = S_IF;
            end
            S_TRAP: begin
                bus.trap = 1'b1;
                if (bus.trap_clr) begin
                    state_d = S_IF;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = S_IF;
        endcase
    end

    // Wait counter: restarts on every state change, counts stalled cycles, wraps on a retried access
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_wait) begin
            wait_d = wait_expired ? '0 : wait_q + 1'b1;
        end
    end

    // Status outputs straight from registered state
    always_comb begin
        bus.state      = state_q;
        bus.trap_cause = cause_q;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: vector table, directed corner sequences, randomized run vs. a spec-level model.
// Three instances: default, TIMEOUT=3 with traps, TIMEOUT=3 with traps disabled.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       IntMemRead, IRWrite, PCWrite, PCWriteCond, PCSrc, FlagSel;
        logic       IRRead, RegRead, Muxgrp, MemtoReg, RegWrite, MemRead, MemWrite;
        logic [1:0] ALUSrc1, ALUSrc2;
        logic [2:0] ALUop;
        logic [4:0] state;
        logic       retire, trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic [3:0] op, fn;
        logic       ir, dr, tc;
        logic [4:0] st;
        logic       ret;
        logic [2:0] alu;
        logic [6:0] strb;   // {PCWrite, PCWriteCond, FlagSel, RegWrite, MemRead, MemWrite, trap}
        logic [1:0] cause;
    } vec_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] kind;   // 0 reg ALU, 1 imm ALU, 2 shift, 3 branch, 4 jump, 5 load, 6 store
        logic [2:0] alu;
        logic       flag;
    } mdec_t;

    typedef struct {
        int         st;
        int         waits;
        int         cause;
        logic [3:0] op, fn;
    } mdl_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;
    outs_t dut_o [3];
    mdl_t  m [3];
    int    tmo [3] = '{15, 3, 3};
    int    ten [3] = '{1, 1, 0};
    vec_t  tbl [$];

    always #5 clk = ~clk;

    mc_ctrl_fsm_if ifa ();
    mc_ctrl_fsm_if ifb ();
    mc_ctrl_fsm_if ifc ();

    mc_ctrl_fsm #(.TIMEOUT_W(4), .TIMEOUT(15), .TRAP_EN(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    mc_ctrl_fsm #(.TIMEOUT_W(4), .TIMEOUT(3),  .TRAP_EN(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    mc_ctrl_fsm #(.TIMEOUT_W(2), .TIMEOUT(3),  .TRAP_EN(0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    assign dut_o[0] = {ifa.IntMemRead, ifa.IRWrite, ifa.PCWrite, ifa.PCWriteCond, ifa.PCSrc, ifa.FlagSel,
                       ifa.IRRead, ifa.RegRead, ifa.Muxgrp, ifa.MemtoReg, ifa.RegWrite, ifa.MemRead, ifa.MemWrite,
                       ifa.ALUSrc1, ifa.ALUSrc2, ifa.ALUop, ifa.state, ifa.retire, ifa.trap, ifa.trap_cause};
    assign dut_o[1] = {ifb.IntMemRead, ifb.IRWrite, ifb.PCWrite, ifb.PCWriteCond, ifb.PCSrc, ifb.FlagSel,
                       ifb.IRRead, ifb.RegRead, ifb.Muxgrp, ifb.MemtoReg, ifb.RegWrite, ifb.MemRead, ifb.MemWrite,
                       ifb.ALUSrc1, ifb.ALUSrc2, ifb.ALUop, ifb.state, ifb.retire, ifb.trap, ifb.trap_cause};
    assign dut_o[2] = {ifc.IntMemRead, ifc.IRWrite, ifc.PCWrite, ifc.PCWriteCond, ifc.PCSrc, ifc.FlagSel,
                       ifc.IRRead, ifc.RegRead, ifc.Muxgrp, ifc.MemtoReg, ifc.RegWrite, ifc.MemRead, ifc.MemWrite,
                       ifc.ALUSrc1, ifc.ALUSrc2, ifc.ALUop, ifc.state, ifc.retire, ifc.trap, ifc.trap_cause};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input int op, input int fn, input int ir, input int dr, input int tc);
        ifa.op = 4'(op); ifa.func = 4'(fn); ifa.imem_ready = 1'(ir); ifa.dmem_ready = 1'(dr); ifa.trap_clr = 1'(tc);
        ifb.op = 4'(op); ifb.func = 4'(fn); ifb.imem_ready = 1'(ir); ifb.dmem_ready = 1'(dr); ifb.trap_clr = 1'(tc);
        ifc.op = 4'(op); ifc.func = 4'(fn); ifc.imem_ready = 1'(ir); ifc.dmem_ready = 1'(dr); ifc.trap_clr = 1'(tc);
    endtask

    // Reset pulse; returns just after a rising edge with rst released (first IF cycle)
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Next sampling point, then advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input int op, input int fn, input int ir, input int dr, input int tc,
                               input int st, input int ret, input int alu, input int strb, input int cause);
        vec_t r;
        r.op = 4'(op); r.fn = 4'(fn); r.ir = 1'(ir); r.dr = 1'(dr); r.tc = 1'(tc);
        r.st = 5'(st); r.ret = 1'(ret); r.alu = 3'(alu); r.strb = 7'(strb); r.cause = 2'(cause);
        return r;
    endfunction

    // Instruction set as a lookup: legality, class, ALU operation, branch flag
    function automatic mdec_t mdecode(input logic [3:0] op, input logic [3:0] fn);
        mdec_t d;
        d = '{legal: 1'b1, kind: 3'd0, alu: 3'd0, flag: 1'b0};
        case (op)
            4'h8: d.alu = 3'd0;
            4'h9, 4'hA: begin d.kind = 3'd1; d.alu = 3'd0; end
            4'hC: d.alu = 3'd1;
            4'hD, 4'hE: begin d.kind = 3'd1; d.alu = 3'd1; end
            4'hB: d.alu = 3'd5;
            4'hF: d.alu = 3'd6;
            4'h7: begin d.kind = 3'd1; d.alu = 3'd5; end
            4'h6: begin d.kind = 3'd1; d.alu = 3'd6; end
            4'h4: begin d.kind = 3'd3; d.alu = 3'd1; end
            4'h5: begin d.kind = 3'd3; d.alu = 3'd1; d.flag = 1'b1; end
            4'h3: d.kind = 3'd4;
            4'h1: d.kind = 3'd5;
            4'h2: d.kind = 3'd6;
            default: begin
                d.kind  = 3'd2;
                d.legal = (fn >= 4'd1) && (fn <= 4'd3);
                d.alu   = 3'(fn + 4'd1);   // sll=2, srl=3, sra=4
            end
        endcase
        return d;
    endfunction

    function automatic outs_t m_out(input mdl_t s, input logic ir, input logic dr);
        outs_t o;
        mdec_t d;
        o = '0;
        o.state      = 5'(s.st);
        o.trap_cause = 2'(s.cause);
        d = mdecode(s.op, s.fn);
        case (s.st)
            0: begin o.IntMemRead = 1'b1; o.ALUSrc2 = 2'b01; o.PCWrite = ir; o.IRWrite = ir; end
            1: begin o.IRRead = 1'b1; o.RegRead = 1'b1; o.Muxgrp = 1'b1; end
            2: begin
                o.ALUop  = d.alu;
                o.retire = (d.kind < 3'd5);
                if (d.kind <= 3'd2) begin o.MemtoReg = 1'b1; o.RegWrite = 1'b1; end
                case (d.kind)
                    3'd0: o.ALUSrc1 = 2'b01;
                    3'd1: begin o.ALUSrc1 = 2'b10; o.ALUSrc2 = 2'b10; end
                    3'd2: o.ALUSrc1 = 2'b10;
                    3'd3: begin o.PCSrc = 1'b1; o.PCWriteCond = 1'b1; o.ALUSrc1 = 2'b01; o.FlagSel = d.flag; end
                    3'd4: begin o.PCWrite = 1'b1; o.ALUSrc2 = 2'b11; end
                    default: begin o.ALUSrc1 = 2'b01; o.ALUSrc2 = 2'b10; end
                endcase
            end
            3: o.MemRead = 1'b1;
            4: begin o.MemWrite = 1'b1; o.retire = dr; end
            5: begin o.RegWrite = 1'b1; o.retire = 1'b1; end
            default: o.trap = 1'b1;
        endcase
        return o;
    endfunction

    function automatic mdl_t m_step(input mdl_t s, input logic [3:0] op, input logic [3:0] fn,
                                    input logic ir, input logic dr, input logic tc,
                                    input int timeout, input int trap_en);
        mdl_t  n;
        mdec_t d;
        logic  stalled;
        n = s;
        stalled = 1'b0;
        case (s.st)
            0: if (ir) n.st = 1; else stalled = 1'b1;
            1: begin
                d = mdecode(op, fn);
                if (d.legal) begin n.st = 2; n.op = op; n.fn = fn; end
                else if (trap_en != 0) begin n.st = 6; n.cause = 1; end
                else n.st = 0;
            end
            2: begin
                d = mdecode(s.op, s.fn);
                n.st = (d.kind == 3'd5) ? 3 : (d.kind == 3'd6) ? 4 : 0;
            end
            3: if (dr) n.st = 5; else stalled = 1'b1;
            4: if (dr) n.st = 0; else stalled = 1'b1;
            5: n.st = 0;
            default: if (tc) begin n.st = 0; n.cause = 0; end
        endcase
        if (stalled) begin
            // This stalled cycle is wait number (waits+1) of the current access
            if (s.waits + 1 >= timeout) begin
                n.waits = 0;
                if (trap_en != 0) begin n.st = 6; n.cause = 2; end
            end else begin
                n.waits = s.waits + 1;
            end
        end
        if (n.st != s.st) n.waits = 0;
        return n;
    endfunction

    initial begin
        outs_t rst_exp;
        outs_t e;
        logic [3:0] r_op, r_fn;
        logic r_ir, r_dr, r_tc;

        set_in(8, 0, 0, 1, 0);

        // Asynchronous reset before any clock edge: IF outputs with imem_ready low
        #2 rst = 1'b1;
        #1;
        rst_exp = '0;
        rst_exp.IntMemRead = 1'b1;
        rst_exp.ALUSrc2 = 2'b01;
        chk("reset_outputs", 32'(dut_o[0]), 32'(rst_exp));
        ifa.imem_ready = 1'b1;
        #1;
        chk("reset_pcwrite_follows_ready", {30'd0, ifa.PCWrite, ifa.IRWrite}, 32'd3);

        // ---------------- vector table on the default instance ----------------
        // add reg
        tbl.push_back(v(8,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(8,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(8,0,1,1,0, 2,1,0,'b0001000,0));
        // bne
        tbl.push_back(v(5,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(5,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(5,0,1,1,0, 2,1,1,'b0110000,0));
        // beq
        tbl.push_back(v(4,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(4,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(4,0,1,1,0, 2,1,1,'b0100000,0));
        // load with two data-memory wait cycles
        tbl.push_back(v(1,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(1,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(1,0,1,0,0, 2,0,0,'b0000000,0));
        tbl.push_back(v(1,0,1,0,0, 3,0,0,'b0000100,0));
        tbl.push_back(v(1,0,1,0,0, 3,0,0,'b0000100,0));
        tbl.push_back(v(1,0,1,1,0, 3,0,0,'b0000100,0));
        tbl.push_back(v(1,0,1,1,0, 5,1,0,'b0001000,0));
        // illegal shift function -> trap, held, then cleared
        tbl.push_back(v(0,7,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(0,7,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(0,7,1,1,0, 6,0,0,'b0000001,1));
        tbl.push_back(v(0,7,1,1,0, 6,0,0,'b0000001,1));
        tbl.push_back(v(0,7,0,1,1, 6,0,0,'b0000001,1));
        tbl.push_back(v(0,7,0,1,0, 0,0,0,'b0000000,0));
        // sra
        tbl.push_back(v(0,3,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(0,3,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(0,3,1,1,0, 2,1,4,'b0001000,0));
        // store, with a trap_clr pulse in IF that must be ignored
        tbl.push_back(v(2,0,1,1,1, 0,0,0,'b1000000,0));
        tbl.push_back(v(2,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(2,0,1,1,0, 2,0,0,'b0000000,0));
        tbl.push_back(v(2,0,1,1,0, 4,1,0,'b0000010,0));
        // jmp
        tbl.push_back(v(3,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(3,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(3,0,1,1,0, 2,1,0,'b1000000,0));
        // or imm, nand reg, sub imm
        tbl.push_back(v(6,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(6,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(6,0,1,1,0, 2,1,6,'b0001000,0));
        tbl.push_back(v(11,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(11,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(11,0,1,1,0, 2,1,5,'b0001000,0));
        tbl.push_back(v(13,0,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(13,0,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(13,0,1,1,0, 2,1,1,'b0001000,0));
        // srl behind one instruction-memory wait cycle
        tbl.push_back(v(0,2,0,1,0, 0,0,0,'b0000000,0));
        tbl.push_back(v(0,2,1,1,0, 0,0,0,'b1000000,0));
        tbl.push_back(v(0,2,1,1,0, 1,0,0,'b0000000,0));
        tbl.push_back(v(0,2,1,1,0, 2,1,3,'b0001000,0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(int'(tbl[i].op), int'(tbl[i].fn), int'(tbl[i].ir), int'(tbl[i].dr), int'(tbl[i].tc));
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), 32'(ifa.state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_retire", i), 32'(ifa.retire), 32'(tbl[i].ret));
            chk($sformatf("vec%0d_aluop", i), 32'(ifa.ALUop), 32'(tbl[i].alu));
            chk($sformatf("vec%0d_strobes", i),
                32'({ifa.PCWrite, ifa.PCWriteCond, ifa.FlagSel, ifa.RegWrite, ifa.MemRead, ifa.MemWrite, ifa.trap}),
                32'(tbl[i].strb));
            chk($sformatf("vec%0d_cause", i), 32'(ifa.trap_cause), 32'(tbl[i].cause));
            next_cycle();
        end

        // ---------------- instruction-memory timeout, TIMEOUT=3 ----------------
        set_in(8, 0, 0, 1, 0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_wait%0d_b", k), 32'(ifb.state), 32'd0);
            chk($sformatf("tmo_wait%0d_c", k), 32'(ifc.state), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo_trap_state_b", 32'(ifb.state), 32'd6);
        chk("tmo_trap_cause_b", 32'(ifb.trap_cause), 32'd2);
        chk("tmo_trap_flag_b", 32'({ifb.trap, ifb.retire}), 32'b10);
        chk("tmo_notrap_en0_c", 32'(ifc.state), 32'd0);
        next_cycle();
        set_in(8, 0, 0, 1, 1);
        @(negedge clk);
        chk("tmo_clr_cycle_b", 32'(ifb.state), 32'd6);
        next_cycle();
        set_in(8, 0, 0, 1, 0);
        @(negedge clk);
        chk("tmo_after_clr_state_b", 32'(ifb.state), 32'd0);
        chk("tmo_after_clr_cause_b", 32'(ifb.trap_cause), 32'd0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        set_in(8, 0, 1, 1, 0);   // ready rises in the third wait cycle
        @(negedge clk);
        chk("tmo_ready_wins_if_b", 32'(ifb.state), 32'd0);
        chk("tmo_ready_wins_pcw_b", 32'(ifb.PCWrite), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("tmo_ready_wins_id_b", 32'(ifb.state), 32'd1);
        chk("tmo_ready_wins_cause_b", 32'(ifb.trap_cause), 32'd0);
        chk("tmo_retry_id_c", 32'(ifc.state), 32'd1);

        // ---------------- asynchronous reset during MEM_ST ----------------
        set_in(2, 0, 1, 0, 0);
        do_reset();
        repeat (3) next_cycle();
        @(negedge clk);
        chk("arst_in_memst", 32'(ifa.state), 32'd4);
        chk("arst_memwrite_before", 32'(ifa.MemWrite), 32'd1);
        #1 rst = 1'b1;
        ifa.trap_clr = 1'b1;
        ifa.dmem_ready = 1'b1;
        #1;
        chk("arst_state_now", 32'(ifa.state), 32'd0);
        chk("arst_memwrite_now", 32'(ifa.MemWrite), 32'd0);
        chk("arst_no_retire", 32'(ifa.retire), 32'd0);
        chk("arst_intmemread", 32'(ifa.IntMemRead), 32'd1);
        @(posedge clk);
        #1;
        chk("arst_held_state", 32'(ifa.state), 32'd0);
        rst = 1'b0;

        // ---------------- randomized run against the reference model ----------------
        set_in(8, 0, 1, 1, 0);
        do_reset();
        for (int k = 0; k < 3; k++) m[k] = '{st: 0, waits: 0, cause: 0, op: 4'd0, fn: 4'd0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r_op = 4'($urandom_range(0, 15));
            r_fn = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
            r_ir = ($urandom_range(0, 3) != 0);
            r_dr = ($urandom_range(0, 3) != 0);
            r_tc = ($urandom_range(0, 3) == 0);
            set_in(int'(r_op), int'(r_fn), int'(r_ir), int'(r_dr), int'(r_tc));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                e = m_out(m[k], r_ir, r_dr);
                chk($sformatf("rand_dut%0d_cyc%0d", k, cyc), 32'(dut_o[k]), 32'(e));
                m[k] = m_step(m[k], r_op, r_fn, r_ir, r_dr, r_tc, tmo[k], ten[k]);
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the 4-bit-opcode datapath. It sequences fetch, decode, execute, memory and write-back, and drives every datapath control strobe. Over the previous-generation controller it adds:
- ready/wait handshakes on instruction and data memory;
- a programmable memory timeout;
- illegal-instruction and bus-error trapping;
- an instruction-retire pulse;
- fully defined (non-latching) outputs in every state.

## Interface
Parameters:
- TIMEOUT_W, 4: width of the memory wait counter.
- TIMEOUT, 15: maximum wait cycles for a memory access before a bus-error trap (1 ≤ TIMEOUT ≤ 2^TIMEOUT_W − 1).
- TRAP_EN, 1: 1 enables the TRAP state; 0 sends illegal opcodes to IF, and a timeout retries the access.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  4  opcode field of the instruction register
- func  in  4  function field (shift group only)
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory completes access this cycle
- trap_clr  in  1  leave TRAP, resume at IF
- IntMemRead, IRWrite, PCWrite, PCWriteCond, PCSrc, FlagSel, IRRead, RegRead, Muxgrp, MemtoReg, RegWrite, MemRead, MemWrite  out  1 each  datapath strobes
- ALUSrc1, ALUSrc2  out  2 each  ALU operand selects
- ALUop  out  3  000 add, 001 sub, 010 sll, 011 srl, 100 sra, 101 nand, 110 or
- state  out  5  current state code (debug)
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- trap  out  1  high while in TRAP
- trap_cause  out  2  00 none, 01 illegal op, 10 bus timeout; held until trap_clr/rst

## Operation
- States and codes: IF=0, ID=1, EX=2, MEM_LD=3, MEM_ST=4, WB=5, TRAP=6.
- Instruction class (ALU kind, branch, jump, load, store) is latched into a class register on the ID→EX edge.
- Every output defaults to 0 in every state; only the listed strobes are driven.
- IF:
  - IntMemRead=1, ALUSrc1=00, ALUSrc2=01, ALUop=000.
  - PCWrite=IRWrite=1 only in the cycle imem_ready=1; that same cycle moves to ID.
- ID: IRRead=RegRead=Muxgrp=1. Decode:
  - 1000 add reg; 1001/1010 add imm; 1100 sub reg; 1101/1110 sub imm.
  - 0000 with func 0001/0010/0011: sll/srl/sra. Any other func is illegal.
  - 1011 nand reg; 1111 or reg; 0111 nand imm; 0110 or imm.
  - 0100 beq; 0101 bne; 0011 jmp; 0001 load; 0010 store.
  - Legal ops go to EX. Illegal ops go to TRAP (cause 01), or to IF when TRAP_EN=0.
- EX:
  - Register ALU ops: ALUSrc1=01, ALUSrc2=00, MemtoReg=RegWrite=1.
  - Immediate ALU ops: ALUSrc1=10, ALUSrc2=10, MemtoReg=RegWrite=1.
  - Shifts: ALUSrc1=10, ALUSrc2=00, MemtoReg=RegWrite=1.
  - beq/bne: PCSrc=1, PCWriteCond=1, ALUSrc1=01, ALUSrc2=00, ALUop=001, FlagSel=0 (beq) or 1 (bne).
  - jmp: PCWrite=1, ALUSrc1=00, ALUSrc2=11, ALUop=000.
  - load/store: ALUSrc1=01, ALUSrc2=10, ALUop=000. Next state is MEM_LD or MEM_ST; all other classes retire and go to IF.
- MEM_LD: MemRead=1 until dmem_ready, then → WB.
- MEM_ST: MemWrite=1 until dmem_ready, then retire and → IF.
- WB: MemtoReg=0, RegWrite=1; retire and → IF.
- Wait counter:
  - Cleared on entry to IF, MEM_LD or MEM_ST.
  - Increments each cycle the relevant ready is low.
  - When it reaches TIMEOUT−1 with ready still low, the next state is TRAP (cause 10). With TRAP_EN=0 it instead clears and the access continues.
- TRAP: trap=1, all strobes 0. Held until trap_clr=1, then → IF with trap_cause cleared.

## Timing
- Reset, asynchronous: state=IF, wait counter=0, class register=0, trap_cause=00. All outputs take their IF values immediately: IntMemRead=1, ALUSrc2=01, everything else 0, with PCWrite/IRWrite following imem_ready.
- Latency with ready always high:
  - ALU, branch and jump ops: 3 cycles (IF, ID, EX).
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- retire is high in exactly one cycle per instruction. It is never asserted for trapped instructions.
- A ready arriving in the same cycle the counter reaches TIMEOUT−1: ready wins and no trap is taken.
- trap_clr outside TRAP is ignored.
- rst asserted mid-instruction aborts it with no retire; rst dominates trap_clr.

## Test plan
- Reset and ready held high, op=1000 → states 0,1,2,0; retire in the EX cycle; ALUop=000 and RegWrite=1 in EX; 3-cycle period.
- op=0001, dmem_ready low for 2 cycles → IF,ID,EX,MEM_LD×3,WB; MemRead high for all 3 MEM_LD cycles; RegWrite only in WB; single retire.
- op=0101 → EX drives PCWriteCond=1, FlagSel=1, ALUop=001, PCWrite=0.
- op=0000, func=0111 → TRAP with trap=1 and trap_cause=01, no retire; trap_clr pulse → IF with trap_cause=00.
- TIMEOUT=3, imem_ready held low → TRAP with cause 10 after 3 IF cycles. Repeat with ready rising in cycle 3 → ID, no trap.
- rst asserted asynchronously during MEM_ST → state=IF immediately, MemWrite=0, no retire.
